maxpool_unit: RTL and testbench
===============================

MAXPOOL_UNIT -- requirements
Module: maxpool_unit

Interface
REQ-001 The module SHALL have parameter DIM_W, default 16, setting the width of the W/H/C dimension registers and counters.
REQ-002 The module SHALL have parameter IN_BASE, default 0, giving the input-buffer base word address.
REQ-003 The module SHALL have parameter OUT_BASE, default 0, giving the output-buffer base word address.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  reset; synchronous, active-low.
REQ-006 Port start  input  1  one-cycle pulse that launches a pooling layer; sampled only in IDLE.
REQ-007 Port done  output  1  one-cycle pulse when the layer completes.
REQ-008 Ports param_o, bias_o, weight_o, input_o, output_o  sp_ram_intf.compute  cs 1 / oe 1 / W_req 1 / addr 32 / W_data 32 / R_data 32  one bus per buffer, toward the bus switcher in MAX_POOL_MODE.
REQ-009 Bus semantics SHALL be: cs=1 selects; oe=1 with W_req=0 is a read whose R_data is valid the next cycle; W_req=1 is a word write of W_data.

Function
REQ-010 bias_o and weight_o SHALL be driven permanently with cs=0, oe=0, W_req=0, addr=0, W_data=0.
REQ-011 Param words SHALL be: addr 0 = W, addr 1 = H, addr 2 = C; each field is in bits [DIM_W-1:0].
REQ-012 Each input/output word SHALL pack 4 signed int8 channels: lane n is in bits [8n+7:8n].
REQ-013 The channel-group count SHALL be G = C/4; the low 2 bits of C SHALL be ignored.
REQ-014 The input address SHALL be IN_BASE + (g*H + y)*W + x.
REQ-015 The output address SHALL be OUT_BASE + (g*Ho + yo)*Wo + xo, with Wo = W>>1 and Ho = H>>1; an odd last row/column SHALL be dropped.
REQ-016 The FSM SHALL have states IDLE, PARAM, PWAIT, CHECK, READ, RWAIT, WRITE, FIN.
REQ-017 IDLE: start=1 SHALL move to PARAM; start SHALL be ignored in all other states.
REQ-018 PARAM: for 3 cycles, read addresses 0, 1, 2 on param_o; R_data SHALL be captured the cycle after each read.
REQ-019 PWAIT: capture C, then go to CHECK.
REQ-020 CHECK: if W<2, H<2 or G=0, go to FIN with no writes; otherwise go to READ with g, yo, xo = 0.
REQ-021 READ: for 4 cycles k = 0..3, read window element (2yo+(k>>1), 2xo+(k&1)) on input_o.
REQ-022 RWAIT: capture the 4th element of the window.
REQ-023 For each lane, the running maximum SHALL be a signed compare: the first element SHALL initialise it, and later elements SHALL replace it only if strictly greater.
REQ-024 WRITE: drive exactly one cycle with output_o cs=1, W_req=1, addr per REQ-015, W_data = 4 lane maxima.
REQ-025 After WRITE, xo SHALL increment; on wrap xo->0 yo SHALL increment; on wrap yo->0 g SHALL increment; after the last g the FSM SHALL go to FIN, otherwise to READ.
REQ-026 FIN: done=1 for one cycle, then go to IDLE.
REQ-027 Each output pixel SHALL take exactly 6 cycles (READ×4, RWAIT, WRITE).
REQ-028 Total latency from start to done SHALL be 6 + 6·G·Ho·Wo cycles for valid dimensions, and 6 cycles for the CHECK-reject case.
REQ-029 In every state not issuing an access, all bus outputs SHALL be 0.
REQ-030 output_o SHALL never read.
REQ-031 input_o and param_o SHALL never write.
REQ-032 The address arithmetic SHALL be 32-bit unsigned; overflow SHALL wrap silently.

Reset
REQ-033 With rst_n=0 at a clock edge, the state SHALL become IDLE, all counters, dimension registers and maxima SHALL become 0, and done plus all bus outputs SHALL become 0 on the following cycle.
REQ-034 A reset asserted mid-layer SHALL abort with no further accesses, done SHALL NOT be pulsed, and a start after release SHALL run a full fresh layer.

Verification
REQ-035 W=4, H=4, C=4; input lane0 = x+4y, other lanes = -(x+4y) -> 4 writes at OUT_BASE+0..3; lane0 = 5, 7, 13, 15; other lanes = 0, -2, -8, -10; done at cycle 30.
REQ-036 W=5, H=3, C=8 -> Wo=2, Ho=1, G=2; exactly 4 writes; column 4 and row 2 are never read; done at cycle 30.
REQ-037 W=1, H=4, C=4 -> zero accesses to input_o/output_o; done exactly 6 cycles after start.
REQ-038 Window of all 0x80 (-128) except one 0x7F in lane 2 -> W_data = 0x807F8080.
REQ-039 Reset asserted during the 2nd WRITE -> no further cs on any bus, no done; a restart produces the identical full write sequence.
REQ-040 start re-pulsed while busy -> ignored; write count and done timing unchanged.

Source files
------------

// File: rtl/maxpool_unit_if.sv
// Single-port RAM bus between the compute unit and a buffer. R_data is valid the cycle after a
// read (cs=1, oe=1, W_req=0).
interface sp_ram_intf;
   logic        cs;
   logic        oe;
   logic        W_req;
   logic [31:0] addr;
   logic [31:0] W_data;
   logic [31:0] R_data;

   modport compute (output cs, oe, W_req, addr, W_data, input R_data);
   modport master  (output cs, oe, W_req, addr, W_data, input R_data);
   modport slave   (input cs, oe, W_req, addr, W_data, output R_data);
endinterface

// File: rtl/maxpool_unit.sv
// 2x2 stride-2 max pooling over packed int8x4 feature maps. Layer dimensions are fetched from
// the param buffer at start; each output word costs a 6-cycle window sweep.
module maxpool_unit #(
   parameter int unsigned DIM_W    = 16,
   parameter logic [31:0] IN_BASE  = 32'd0,
   parameter logic [31:0] OUT_BASE = 32'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        done,
   sp_ram_intf.compute param_o,
   sp_ram_intf.compute bias_o,
   sp_ram_intf.compute weight_o,
   sp_ram_intf.compute input_o,
   sp_ram_intf.compute output_o
);

   typedef enum logic [2:0] {
      StIdle, StParam, StPwait, StCheck, StRead, StRwait, StWrite, StFin
   } state_e;

   state_e           state_q;
   logic [1:0]       k_q;
   logic [DIM_W-1:0] w_q, h_q, c_q;
   logic [DIM_W-1:0] g_q, yo_q, xo_q;
   logic [31:0]      mx_q;

   logic [DIM_W-1:0] wo, ho, gn;
   logic [DIM_W-1:0] xo_nx, yo_nx, g_nx;
   logic             last_px;
   logic [31:0]      max_nx;
   logic             unused_rdata;

   function automatic logic [31:0] lane_max(input logic [31:0] cur, input logic [31:0] cand);
      logic [31:0] res;
      res = cur;
      for (int n = 0; n < 4; n++) begin
         if ($signed(cand[8*n +: 8]) > $signed(cur[8*n +: 8])) res[8*n +: 8] = cand[8*n +: 8];
      end
      return res;
   endfunction

   function automatic logic [31:0] in_addr(input logic [DIM_W-1:0] g, yo, xo,
                                           input logic [1:0] k,
                                           input logic [DIM_W-1:0] w, h);
      logic [31:0] y, x;
      y = (32'(yo) << 1) + 32'(k[1]);
      x = (32'(xo) << 1) + 32'(k[0]);
      return IN_BASE + (32'(g) * 32'(h) + y) * 32'(w) + x;
   endfunction

   function automatic logic [31:0] out_addr(input logic [DIM_W-1:0] g, yo, xo, wd, ht);
      return OUT_BASE + (32'(g) * 32'(ht) + 32'(yo)) * 32'(wd) + 32'(xo);
   endfunction

   assign wo     = w_q >> 1;
   assign ho     = h_q >> 1;
   assign gn     = c_q >> 2;
   assign max_nx = lane_max(mx_q, input_o.R_data);

   // These buffers are idle in pooling mode.
   assign bias_o.cs       = 1'b0;
   assign bias_o.oe       = 1'b0;
   assign bias_o.W_req    = 1'b0;
   assign bias_o.addr     = '0;
   assign bias_o.W_data   = '0;
   assign weight_o.cs     = 1'b0;
   assign weight_o.oe     = 1'b0;
   assign weight_o.W_req  = 1'b0;
   assign weight_o.addr   = '0;
   assign weight_o.W_data = '0;
   assign unused_rdata    = ^{bias_o.R_data, weight_o.R_data, output_o.R_data, param_o.R_data};

   // Raster order xo -> yo -> g; last_px flags the final output pixel of the layer.
   always_comb begin
      xo_nx   = xo_q + 1'b1;
      yo_nx   = yo_q;
      g_nx    = g_q;
      last_px = 1'b0;
      if (xo_nx == wo) begin
         xo_nx = '0;
         yo_nx = yo_q + 1'b1;
         if (yo_nx == ho) begin
            yo_nx   = '0;
            g_nx    = g_q + 1'b1;
            last_px = (g_nx == gn);
         end
      end
   end

   // Bus outputs default to idle every cycle; only the cycle issuing an access sets them.
   always_ff @(posedge clk) begin
      done            <= 1'b0;
      param_o.cs      <= 1'b0;
      param_o.oe      <= 1'b0;
      param_o.W_req   <= 1'b0;
      param_o.addr    <= '0;
      param_o.W_data  <= '0;
      input_o.cs      <= 1'b0;
      input_o.oe      <= 1'b0;
      input_o.W_req   <= 1'b0;
      input_o.addr    <= '0;
      input_o.W_data  <= '0;
      output_o.cs     <= 1'b0;
      output_o.oe     <= 1'b0;
      output_o.W_req  <= 1'b0;
      output_o.addr   <= '0;
      output_o.W_data <= '0;
      if (!rst_n) begin
         state_q <= StIdle;
         k_q     <= '0;
         w_q     <= '0;
         h_q     <= '0;
         c_q     <= '0;
         g_q     <= '0;
         yo_q    <= '0;
         xo_q    <= '0;
         mx_q    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q      <= StParam;
                  k_q          <= '0;
                  param_o.cs   <= 1'b1;
                  param_o.oe   <= 1'b1;
               end
            end
            StParam: begin
               // Data for the read issued last cycle is on R_data now.
               if (k_q == 2'd1) w_q <= param_o.R_data[DIM_W-1:0];
               if (k_q == 2'd2) begin
                  h_q     <= param_o.R_data[DIM_W-1:0];
                  state_q <= StPwait;
               end else begin
                  k_q          <= k_q + 2'd1;
                  param_o.cs   <= 1'b1;
                  param_o.oe   <= 1'b1;
                  param_o.addr <= 32'(k_q) + 32'd1;
               end
            end
            StPwait: begin
               c_q     <= param_o.R_data[DIM_W-1:0];
               state_q <= StCheck;
            end
            StCheck: begin
               if (w_q < DIM_W'(2) || h_q < DIM_W'(2) || gn == '0) begin
                  state_q <= StFin;
                  done    <= 1'b1;
               end else begin
                  state_q      <= StRead;
                  k_q          <= '0;
                  g_q          <= '0;
                  yo_q         <= '0;
                  xo_q         <= '0;
                  input_o.cs   <= 1'b1;
                  input_o.oe   <= 1'b1;
                  input_o.addr <= in_addr('0, '0, '0, 2'd0, w_q, h_q);
               end
            end
            StRead: begin
               if (k_q == 2'd1) mx_q <= input_o.R_data;
               else if (k_q != 2'd0) mx_q <= max_nx;
               if (k_q == 2'd3) begin
                  state_q <= StRwait;
               end else begin
                  k_q          <= k_q + 2'd1;
                  input_o.cs   <= 1'b1;
                  input_o.oe   <= 1'b1;
                  input_o.addr <= in_addr(g_q, yo_q, xo_q, k_q + 2'd1, w_q, h_q);
               end
            end
            StRwait: begin
               mx_q            <= max_nx;
               state_q         <= StWrite;
               output_o.cs     <= 1'b1;
               output_o.W_req  <= 1'b1;
               output_o.addr   <= out_addr(g_q, yo_q, xo_q, wo, ho);
               output_o.W_data <= max_nx;
            end
            StWrite: begin
               xo_q <= xo_nx;
               yo_q <= yo_nx;
               g_q  <= g_nx;
               if (last_px) begin
                  state_q <= StFin;
                  done    <= 1'b1;
               end else begin
                  state_q      <= StRead;
                  k_q          <= '0;
                  input_o.cs   <= 1'b1;
                  input_o.oe   <= 1'b1;
                  input_o.addr <= in_addr(g_nx, yo_nx, xo_nx, 2'd0, w_q, h_q);
               end
            end
            StFin: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_maxpool_unit.sv
// Directed bench for maxpool_unit: RAM models on every bus, expected writes queued at launch
// and popped as the unit writes, plus latency/access-count checks per layer.
module tb_maxpool_unit;
   localparam logic [31:0] IN_BASE  = 32'h0000_0100;
   localparam logic [31:0] OUT_BASE = 32'h0000_0400;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic done;

   sp_ram_intf pif ();
   sp_ram_intf bif ();
   sp_ram_intf wif ();
   sp_ram_intf iif ();
   sp_ram_intf oif ();

   maxpool_unit #(.DIM_W(16), .IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .done     (done),
      .param_o  (pif),
      .bias_o   (bif),
      .weight_o (wif),
      .input_o  (iif),
      .output_o (oif)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;
   int cs_cnt = 0;
   int cur_w = 1, cur_h = 1, cur_g = 0;
   logic bad_read = 1'b0;
   logic bad_bus = 1'b0;
   logic [31:0] off;
   logic [31:0] pmem [4];
   logic [31:0] imem [64];
   wr_t exp_q[$];
   wr_t got;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Buffer RAMs: one-cycle read latency.
   always @(posedge clk) begin
      if (pif.cs && pif.oe && !pif.W_req) pif.R_data <= pmem[pif.addr[1:0]];
      if (iif.cs && iif.oe && !iif.W_req) iif.R_data <= imem[6'(iif.addr - IN_BASE)];
   end
   assign bif.R_data = '0;
   assign wif.R_data = '0;
   assign oif.R_data = '0;

   always @(negedge clk) begin
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (pif.cs || iif.cs || oif.cs || bif.cs || wif.cs) cs_cnt++;
      if (bif.cs || bif.oe || bif.W_req || (|bif.addr) || (|bif.W_data) ||
          wif.cs || wif.oe || wif.W_req || (|wif.addr) || (|wif.W_data)) bad_bus = 1'b1;
      if ((pif.cs && (pif.W_req || pif.addr > 32'd2)) || (iif.cs && iif.W_req) ||
          (oif.cs && oif.oe)) bad_bus = 1'b1;
      if (iif.cs) begin
         rd_cnt++;
         off = iif.addr - IN_BASE;
         if (off >= 32'(cur_w * cur_h * cur_g) ||
             (off % 32'(cur_w)) >= 32'((cur_w / 2) * 2) ||
             ((off / 32'(cur_w)) % 32'(cur_h)) >= 32'((cur_h / 2) * 2)) bad_read = 1'b1;
      end
      if (oif.cs) begin
         wr_cnt++;
         if (exp_q.size() != 0) begin
            got = exp_q.pop_front();
            chk("wr_addr", oif.addr, got.addr);
            chk("wr_data", oif.W_data, got.data);
            chk("wr_req", 32'(oif.W_req), 32'd1);
         end
      end
   end

   task automatic set_params(input int w, input int h, input int c);
      pmem[0] = {16'hA5A5, 16'(w)};
      pmem[1] = {16'h5A5A, 16'(h)};
      pmem[2] = {16'hC3C3, 16'(c)};
      pmem[3] = 32'h0;
      cur_w = w;
      cur_h = h;
      cur_g = c / 4;
   endtask

   task automatic fill_t1();
      logic [7:0] p, n;
      for (int v = 0; v < 16; v++) begin
         p = 8'(v);
         n = 8'(-v);
         imem[v] = {n, n, n, p};
      end
   endtask

   task automatic push_t1();
      logic [31:0] d [4];
      wr_t e;
      d[0] = 32'h0000_0005;
      d[1] = 32'hFEFE_FE07;
      d[2] = 32'hF8F8_F80D;
      d[3] = 32'hF6F6_F60F;
      for (int i = 0; i < 4; i++) begin
         e.addr = OUT_BASE + 32'(i);
         e.data = d[i];
         exp_q.push_back(e);
      end
   endtask

   // Reference pooling straight from the input image.
   task automatic push_model(input int w, input int h, input int c);
      wr_t e;
      logic [31:0] m, v;
      for (int g = 0; g < c / 4; g++)
         for (int yo = 0; yo < h / 2; yo++)
            for (int xo = 0; xo < w / 2; xo++) begin
               for (int k = 0; k < 4; k++) begin
                  v = imem[(g * h + 2 * yo + k / 2) * w + 2 * xo + k % 2];
                  if (k == 0) m = v;
                  else
                     for (int n = 0; n < 4; n++)
                        if ($signed(v[8*n +: 8]) > $signed(m[8*n +: 8])) m[8*n +: 8] = v[8*n +: 8];
               end
               e.addr = OUT_BASE + 32'(((g * (h / 2) + yo) * (w / 2)) + xo);
               e.data = m;
               exp_q.push_back(e);
            end
   endtask

   task automatic pulse_start(output int t0);
      @(negedge clk);
      #1;
      start = 1'b1;
      t0 = cyc;
      @(negedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_layer(input int w, input int h, input int c, input int exp_lat,
                            input int exp_wr, input int exp_rd, input bit repulse);
      int s, d0, w0, r0, n;
      d0 = done_cnt;
      w0 = wr_cnt;
      r0 = rd_cnt;
      bad_read = 1'b0;
      set_params(w, h, c);
      pulse_start(s);
      if (repulse) begin
         repeat (8) @(negedge clk);
         #1;
         start = 1'b1;
         @(negedge clk);
         #1;
         start = 1'b0;
      end
      n = 0;
      while (done_cnt == d0 && n < 1000) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("done_seen", 32'(done_cnt), 32'(d0 + 1));
      chk("latency", 32'(done_cyc - s), 32'(exp_lat));
      chk("write_count", 32'(wr_cnt - w0), 32'(exp_wr));
      chk("read_count", 32'(rd_cnt - r0), 32'(exp_rd));
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      chk("read_window", 32'(bad_read), 32'd0);
      @(negedge clk);
      #1;
      chk("done_one_cycle", 32'(done), 32'd0);
      repeat (3) @(negedge clk);
      chk("no_late_done", 32'(done_cnt), 32'(d0 + 1));
   endtask

   initial begin
      int s, n, w0, cs0, d0;
      wr_t e;
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_param_cs", 32'(pif.cs), 32'd0);
      chk("rst_input_cs", 32'(iif.cs), 32'd0);
      chk("rst_output_cs", 32'(oif.cs), 32'd0);
      chk("rst_output_addr", oif.addr, 32'd0);
      #1;
      rst_n = 1'b1;

      // 4x4x4 ramp, with a stray start pulse while busy
      fill_t1();
      push_t1();
      run_layer(4, 4, 4, 30, 4, 16, 1'b1);

      // 5x3x8: odd column/row dropped, two channel groups
      for (int i = 0; i < 30; i++) imem[i] = $urandom;
      push_model(5, 3, 8);
      run_layer(5, 3, 8, 30, 4, 16, 1'b0);

      // W=1 rejected by CHECK
      run_layer(1, 4, 4, 6, 0, 0, 1'b0);

      // Signed compare: -128 everywhere but one +127 in lane 2
      for (int i = 0; i < 4; i++) imem[i] = 32'h8080_8080;
      imem[1] = 32'h807F_8080;
      e.addr = OUT_BASE;
      e.data = 32'h807F_8080;
      exp_q.push_back(e);
      run_layer(2, 2, 6, 12, 1, 4, 1'b0);

      // Reset during the second WRITE, then a clean restart
      fill_t1();
      push_t1();
      set_params(4, 4, 4);
      w0 = wr_cnt;
      pulse_start(s);
      n = 0;
      while (wr_cnt - w0 < 2 && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      rst_n = 1'b0;
      cs0 = cs_cnt;
      d0 = done_cnt;
      chk("abort_writes", 32'(wr_cnt - w0), 32'd2);
      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("abort_no_cs", 32'(cs_cnt), 32'(cs0));
      chk("abort_no_done", 32'(done_cnt), 32'(d0));
      chk("abort_pending", 32'(exp_q.size()), 32'd2);
      exp_q.delete();
      push_t1();
      run_layer(4, 4, 4, 30, 4, 16, 1'b0);

      chk("idle_buses", 32'(bad_bus), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
